// File: rtl/key_debounce_multi_if.sv
// Key pins and conditioned key outputs of key_debounce_multi, bundled as one port.
// The slave side is the debouncer and the master side is the pin/stimulus owner.
interface key_debounce_multi_if #(
  parameter int NUM_KEYS = 4
) ();
  logic [NUM_KEYS-1:0] key;
  logic [NUM_KEYS-1:0] key_value;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_long;
  logic [NUM_KEYS-1:0] key_repeat;

  modport master (
    output key,
    input  key_value,
    input  key_press,
    input  key_release,
    input  key_long,
    input  key_repeat
  );

  modport slave (
    input  key,
    output key_value,
    output key_press,
    output key_release,
    output key_long,
    output key_repeat
  );
endinterface

// File: rtl/key_debounce_multi.sv
// N-channel active-low key conditioner: sync, debounce, press/release/long pulses.
// Define KEY_REPEAT_EN to add auto-repeat pulses after a long press.
module key_debounce_multi #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int CNT_W           = 32
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  key_debounce_multi_if.slave  kbus
);

  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_CYCLES);

  logic [NUM_KEYS-1:0] w_key_value;
  logic [NUM_KEYS-1:0] w_key_press;
  logic [NUM_KEYS-1:0] w_key_release;
  logic [NUM_KEYS-1:0] w_key_long;
  logic [NUM_KEYS-1:0] w_key_repeat;

  assign kbus.key_value   = w_key_value;
  assign kbus.key_press   = w_key_press;
  assign kbus.key_release = w_key_release;
  assign kbus.key_long    = w_key_long;
  assign kbus.key_repeat  = w_key_repeat;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    logic             r_s1;
    logic             r_s2;
    logic             r_prev;
    logic             r_value;
    logic             r_press;
    logic             r_release;
    logic             r_long;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hold;
    logic             w_accept;
    logic             w_hold_inc;
    logic             w_long_hit;
    logic [CNT_W-1:0] w_hold_p1;

    // Acceptance fires only on the last count of a quiet window, so a
    // bounce that settles back to the current level produces nothing.
    always_comb begin
      w_accept   = 1'b0;
      w_hold_inc = 1'b0;
      w_long_hit = 1'b0;
      w_hold_p1  = r_hold + ONE_C;
      if ((r_cnt == ONE_C) && (r_s2 == r_prev) && (r_s2 != r_value)) begin
        w_accept = 1'b1;
      end else begin
        w_accept = 1'b0;
      end
      if (!r_value && (r_hold < LONG_C)) begin
        w_hold_inc = 1'b1;
        w_long_hit = (w_hold_p1 == LONG_C);
      end else begin
        w_hold_inc = 1'b0;
        w_long_hit = 1'b0;
      end
    end

    // Synchroniser, debounce window, accepted level, event pulses and hold timer.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
        r_s1      <= 1'b1;
        r_s2      <= 1'b1;
        r_prev    <= 1'b1;
        r_value   <= 1'b1;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        r_cnt     <= ZERO_C;
        r_hold    <= ZERO_C;
      end else begin
        r_s1   <= kbus.key[g];
        r_s2   <= r_s1;
        r_prev <= r_s2;

        if (r_s2 != r_prev) begin
          r_cnt <= DEB_C;
        end else if (r_cnt != ZERO_C) begin
          r_cnt <= r_cnt - ONE_C;
        end else begin
          r_cnt <= ZERO_C;
        end

        r_press   <= w_accept & ~r_s2;
        r_release <= w_accept & r_s2;

        if (w_accept) begin
          r_value <= r_s2;
        end else begin
          r_value <= r_value;
        end

        // Hold timer saturates at LONG_CYCLES, so key_long fires once per press.
        if (w_accept) begin
          r_hold <= ZERO_C;
          r_long <= 1'b0;
        end else if (w_hold_inc) begin
          r_hold <= w_hold_p1;
          r_long <= w_long_hit;
        end else begin
          r_hold <= r_hold;
          r_long <= 1'b0;
        end
      end
    end

    assign w_key_value[g]   = r_value;
    assign w_key_press[g]   = r_press;
    assign w_key_release[g] = r_release;
    assign w_key_long[g]    = r_long;

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_C = CNT_W'(REPEAT_CYCLES);

    logic             r_rpt_act;
    logic             r_rpt;
    logic [CNT_W-1:0] r_rpt_cnt;
    logic [CNT_W-1:0] w_rpt_p1;

    // Repeat-interval arithmetic kept out of the sequential block.
    always_comb begin
      w_rpt_p1 = r_rpt_cnt + ONE_C;
    end

    // Repeat timer arms on the long-press cycle and disarms on any level change.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
        r_rpt_act <= 1'b0;
        r_rpt     <= 1'b0;
        r_rpt_cnt <= ZERO_C;
      end else begin
        if (w_accept) begin
          r_rpt_act <= 1'b0;
          r_rpt_cnt <= ZERO_C;
          r_rpt     <= 1'b0;
        end else if (w_long_hit) begin
          r_rpt_act <= 1'b1;
          r_rpt_cnt <= ZERO_C;
          r_rpt     <= 1'b0;
        end else if (r_rpt_act && !r_value) begin
          r_rpt_act <= 1'b1;
          if (w_rpt_p1 == RPT_C) begin
            r_rpt_cnt <= ZERO_C;
            r_rpt     <= 1'b1;
          end else begin
            r_rpt_cnt <= w_rpt_p1;
            r_rpt     <= 1'b0;
          end
        end else begin
          r_rpt_act <= r_rpt_act;
          r_rpt_cnt <= r_rpt_cnt;
          r_rpt     <= 1'b0;
        end
      end
    end

    assign w_key_repeat[g] = r_rpt;
`else
    assign w_key_repeat[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Self-checking bench for key_debounce_multi: directed test-plan steps plus
// random key activity, checked against a sliding-window reference model.
module tb_key_debounce_multi;
  localparam int NK   = 2;
  localparam int DEB  = 8;
  localparam int LONG = 20;
  localparam int REP  = 5;
  localparam int CW   = 32;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  key_debounce_multi_if #(.NUM_KEYS(NK)) kbus ();

  key_debounce_multi #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG),
    .REPEAT_CYCLES(REP), .CNT_W(CW)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .kbus    (kbus)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: a level is accepted once the synchronised samples
  // (two edges old) have agreed for DEB+1 consecutive edges.
  bit            hq [NK][$];
  logic [NK-1:0] m_val;
  int            m_held [NK];
  int            m_since [NK];
  logic [NK-1:0] e_press, e_rel, e_long, e_rpt;

  int errors = 0;
  int checks = 0;
  int edge_no = 0;
  int e0;
  int n_press [NK], n_rel [NK], n_long [NK], n_rpt [NK];
  int at_press [NK], at_long [NK];
  int exp_rpt;

  task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NK; c++) begin
      hq[c].delete();
      for (int k = 0; k < DEB + 3; k++) hq[c].push_back(1'b1);
      m_held[c]  = 0;
      m_since[c] = -1;
    end
    m_val   = '1;
    e_press = '0;
    e_rel   = '0;
    e_long  = '0;
    e_rpt   = '0;
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NK; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0; n_rpt[c] = 0;
      at_press[c] = -1; at_long[c] = -1;
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    edge_no++;
    e_press = '0; e_rel = '0; e_long = '0; e_rpt = '0;
    if (!sys_rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < NK; c++) begin
        bit v;
        bit same;
        hq[c].push_front(kbus.key[c]);
        void'(hq[c].pop_back());
        v = hq[c][2];
        same = 1'b1;
        for (int k = 3; k <= DEB + 2; k++) if (hq[c][k] != v) same = 1'b0;
        if (same && (v != m_val[c])) begin
          m_val[c]   = v;
          e_press[c] = ~v;
          e_rel[c]   = v;
          m_held[c]  = 0;
          m_since[c] = -1;
        end else if (!m_val[c]) begin
          if (m_held[c] < LONG) begin
            m_held[c]++;
            if (m_held[c] == LONG) begin
              e_long[c]  = 1'b1;
              m_since[c] = 0;
            end
          end else if (m_since[c] >= 0) begin
            m_since[c]++;
`ifdef KEY_REPEAT_EN
            if (m_since[c] % REP == 0) e_rpt[c] = 1'b1;
`endif
          end
        end
      end
    end
    #1;
    chk("key_value", kbus.key_value, m_val);
    chk("key_press", kbus.key_press, e_press);
    chk("key_release", kbus.key_release, e_rel);
    chk("key_long", kbus.key_long, e_long);
    chk("key_repeat", kbus.key_repeat, e_rpt);
    for (int c = 0; c < NK; c++) begin
      if (kbus.key_press[c] === 1'b1) begin n_press[c]++; at_press[c] = edge_no; end
      if (kbus.key_release[c] === 1'b1) n_rel[c]++;
      if (kbus.key_long[c] === 1'b1) begin n_long[c]++; at_long[c] = edge_no; end
      if (kbus.key_repeat[c] === 1'b1) n_rpt[c]++;
    end
  endtask

  initial begin
    kbus.key = 2'b11;
    model_reset();
    clear_counts();
    #1 sys_rst = 1'b0;
    #1;
    chk("rst_value", kbus.key_value, 2'b11);
    chk("rst_press", kbus.key_press | kbus.key_release | kbus.key_long | kbus.key_repeat, 2'b00);
    repeat (3) tick();
    #2 sys_rst = 1'b1;

    // Idle after reset: no pulses for 50 cycles
    clear_counts();
    repeat (50) tick();
    chk_int("idle_pulses", n_press[0] + n_press[1] + n_rel[0] + n_rel[1] + n_long[0] + n_long[1], 0);

    // Clean press on key 0
    clear_counts();
    e0 = edge_no;
    kbus.key = 2'b10;
    repeat (20) tick();
    chk_int("press0_latency", at_press[0] - e0, DEB + 3);
    chk_int("press0_count", n_press[0], 1);
    chk_int("press1_quiet", n_press[1], 0);
    kbus.key = 2'b11;
    repeat (20) tick();
    chk_int("release0_count", n_rel[0], 1);

    // Bouncing key 0, then settle low
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      kbus.key = (i % 2 == 0) ? 2'b10 : 2'b11;
      repeat (3) tick();
    end
    e0 = edge_no;
    kbus.key = 2'b10;
    repeat (20) tick();
    chk_int("bounce_latency", at_press[0] - e0, DEB + 3);
    chk_int("bounce_count", n_press[0], 1);
    kbus.key = 2'b11;
    repeat (20) tick();

    // Short glitch is rejected
    clear_counts();
    kbus.key = 2'b10;
    repeat (5) tick();
    kbus.key = 2'b11;
    repeat (20) tick();
    chk_int("glitch_press", n_press[0], 0);
    chk_int("glitch_release", n_rel[0], 0);

    // Both keys held 40 cycles
    clear_counts();
    e0 = edge_no;
    kbus.key = 2'b00;
    repeat (40) tick();
    kbus.key = 2'b11;
    repeat (25) tick();
    for (int c = 0; c < NK; c++) begin
      chk_int("both_press_at", at_press[c] - e0, DEB + 3);
      chk_int("both_long_at", at_long[c] - e0, DEB + 3 + LONG);
      chk_int("both_long_cnt", n_long[c], 1);
      chk_int("both_rel_cnt", n_rel[c], 1);
    end

    // Released after 15 cycles: no long press
    clear_counts();
    kbus.key = 2'b00;
    repeat (15) tick();
    kbus.key = 2'b11;
    repeat (25) tick();
    chk_int("short_long0", n_long[0], 0);
    chk_int("short_long1", n_long[1], 0);
    chk_int("short_press0", n_press[0], 1);

    // Key 0 held 50 cycles past its press
    clear_counts();
    e0 = edge_no;
    kbus.key = 2'b10;
    repeat (DEB + 3 + 50) tick();
    chk_int("hold_long_at", at_long[0] - e0, DEB + 3 + LONG);
`ifdef KEY_REPEAT_EN
    exp_rpt = (50 - LONG) / REP;
`else
    exp_rpt = 0;
`endif
    chk_int("hold_repeat_cnt", n_rpt[0], exp_rpt);
    kbus.key = 2'b11;
    repeat (20) tick();

    // Reset four cycles into a debounce window, key held through it
    clear_counts();
    kbus.key = 2'b10;
    repeat (4) tick();
    #1 sys_rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_value", kbus.key_value, 2'b11);
    repeat (2) tick();
    #2 sys_rst = 1'b1;
    e0 = edge_no;
    clear_counts();
    repeat (20) tick();
    chk_int("midrst_latency", at_press[0] - e0, DEB + 3);
    kbus.key = 2'b11;
    repeat (20) tick();

    // Random key activity against the model
    for (int s = 0; s < 60; s++) begin
      kbus.key = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 40)) tick();
    end
    kbus.key = 2'b11;
    repeat (40) tick();
    chk("final_value", kbus.key_value, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
